// File: rtl/mskaes_ciphertext_outbuf_if.sv
// mskaes_ciphertext_outbuf_if: masked 32-bit beat stream with valid/ready handshake
interface mskaes_ciphertext_outbuf_if #(parameter int d = 2);
  logic out_valid;
  logic out_ready;
  logic [32*d-1:0] sh_out_word;
  logic [1:0] out_idx;
  logic out_last;
  modport master (output out_valid, sh_out_word, out_idx, out_last, input out_ready);
  modport slave (input out_valid, sh_out_word, out_idx, out_last, output out_ready);
endinterface

// File: rtl/mskaes_ciphertext_outbuf.sv
// mskaes_ciphertext_outbuf: buffers masked AES results and streams them as four shared 32-bit beats.
// MSKAES_OUTBUF_CLEAR_EN: wipe consumed entries and blank the idle output word.
module mskaes_ciphertext_outbuf #(
  parameter int d = 2,
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic cipher_valid,
  input  logic [128*d-1:0] sh_ciphertext,
  input  logic core_fetch,
  output logic accept_ok,
  output logic overflow,
  mskaes_ciphertext_outbuf_if.master ob
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  typedef enum logic [1:0] {EMPTY, STREAM, FULL} state_t;
  state_t state;
  logic [128*d-1:0] mem [DEPTH];
  logic [128*d-1:0] head;
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count, inflight;
  logic [1:0] beat;
  logic fire, pop, push, blank;
  always_comb begin
    state = count == '0 ? EMPTY : count == FULL_CNT ? FULL : STREAM;
    fire = ob.out_valid & ob.out_ready;
    pop = fire & (beat == 2'd3);
    push = cipher_valid & ((state != FULL) | pop);
  end
`ifdef MSKAES_OUTBUF_CLEAR_EN
  assign blank = state == EMPTY;
`else
  assign blank = 1'b0;
`endif
  assign head = mem[rptr];
  assign ob.out_valid = state != EMPTY;
  assign ob.out_idx = beat;
  assign ob.out_last = beat == 2'd3;
  // Occupancy plus outstanding encryptions must leave room for every result.
  assign accept_ok = ({1'b0, count} + {1'b0, inflight}) < {1'b0, FULL_CNT};
  for (genvar s = 0; s < d; s++) begin : g_share
    logic [127:0] sh;
    assign sh = head[s*128 +: 128];
    assign ob.sh_out_word[s*32 +: 32] = blank ? 32'd0 : sh[{beat, 5'd0} +: 32];
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      inflight <= '0;
      beat <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (fire) beat <= beat + 2'd1;
      if (pop) rptr <= rptr + AW'(1);
      if (push) wptr <= wptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (core_fetch & ~cipher_valid & (inflight != FULL_CNT)) inflight <= inflight + CW'(1);
      else if (cipher_valid & ~core_fetch & (inflight != '0)) inflight <= inflight - CW'(1);
      if (cipher_valid & ~push) overflow <= 1'b1;
`ifdef MSKAES_OUTBUF_CLEAR_EN
      if (pop) mem[rptr] <= '0;
`endif
      // A push into the slot freed by a simultaneous pop overrides the wipe.
      if (push) mem[wptr] <= sh_ciphertext;
    end
  end
endmodule

// File: doc/mskaes_ciphertext_outbuf.md
# mskaes_ciphertext_outbuf

Output stage placed directly downstream of the masked round-based AES-128 core. Captures the single-cycle `cipher_valid` / `sh_ciphertext` result into a DEPTH-entry FIFO, then streams each result to the consumer as four 32-bit masked words over a valid/ready handshake. Tracks in-flight encryptions and produces `accept_ok`, which the integrator ANDs into the core's `valid_in`, so results are never dropped under backpressure. Data stays shared throughout; no share recombination occurs.

## Interface
- d, 2, masking order (number of shares)
- DEPTH, 2, FIFO entries (power of two, ≥2)
- clk  in  1  clock, rising edge
- nrst  in  1  reset; asynchronous, active-low
- cipher_valid  in  1  core result strobe (one-cycle pulse)
- sh_ciphertext  in  128*d  core result; share s bit b at index s*128+b
- core_fetch  in  1  core accepted a new block this cycle (core `valid_in & ready`)
- accept_ok  out  1  a new block may be started
- out_valid  out  1  `sh_out_word` holds a valid beat
- out_ready  in  1  consumer accepts the beat
- sh_out_word  out  32*d  beat k of the head entry; share s word at [s*32 +: 32] = sh_ciphertext[s*128 + 32k +: 32]
- out_idx  out  2  beat index k (0..3)
- out_last  out  1  high when out_idx==3
- overflow  out  1  sticky: a result was dropped

## Operation
- Storage: DEPTH × 128*d registers, write pointer, read pointer, occupancy `count` (0..DEPTH), beat counter `beat` (0..3), in-flight counter `inflight` (0..DEPTH).
- Push: `cipher_valid` and (count<DEPTH, or a final-beat pop occurs in the same cycle) → write entry at wptr, wptr+1 mod DEPTH.
- Drop: `cipher_valid`, count==DEPTH, and no final-beat pop in the same cycle → entry not written; overflow←1 until reset.
- Beat transfer: out_valid & out_ready → beat+1. At beat==3 → beat←0, rptr+1 mod DEPTH, count−1 (pop).
- count update: +1 on push, −1 on pop, unchanged when both occur.
- inflight: +1 on core_fetch, −1 on cipher_valid, unchanged when both occur. It saturates at 0: a cipher_valid with inflight==0 is still pushed. It saturates at DEPTH.
- accept_ok = (count + inflight) < DEPTH; purely combinational from registers.
- out_valid = (count != 0). sh_out_word, out_idx, and out_last are driven from the head entry and `beat` (mux only, no recombination).
- States (derived from count/beat): EMPTY (count=0); STREAM (count>0, beat 0..3); FULL (count=DEPTH). EMPTY→STREAM on push. STREAM→EMPTY on final-beat pop with count=1 and no push. Otherwise pointers advance.

## Timing
- Reset (async assert, synchronous-release use assumed by integrator): out_valid=0, out_idx=0, out_last=0, overflow=0, accept_ok=1, sh_out_word=0. All pointers, counters, and storage are cleared to 0.
- Push latency: cipher_valid at edge n → out_valid=1 with beat 0 after edge n (visible in cycle n+1), provided the FIFO was empty.
- Throughput: one beat per cycle while out_ready=1. Back-to-back entries have no bubble: beat 0 of the next entry is visible in the cycle after the final beat of the previous one.
- out_ready may toggle freely. sh_out_word and out_idx hold stable while out_valid & ~out_ready.
- Reset asserted mid-stream: the partial entry is discarded and all outputs return to reset values immediately (asynchronously).

## Configuration
- MSKAES_OUTBUF_CLEAR_EN defined: on each pop, the freed entry is overwritten with all-zero shares in the same edge. When the FIFO is EMPTY, sh_out_word is forced to 0. No share material lingers after consumption.
- Undefined: freed entries retain stale data. sh_out_word shows the head-slot contents even when out_valid=0. Behaviour on the handshake is otherwise identical.

## Test plan
- Reset, then a single cipher_valid with share0=0x00112233_44556677_8899AABB_CCDDEEFF and share1=0, and out_ready=1 → in the next 4 cycles, share0 words 0xCCDDEEFF, 0x8899AABB, 0x44556677, 0x00112233 with out_idx 0..3. out_last is high only on the 4th cycle.
- core_fetch twice with DEPTH=2 and no results yet → accept_ok=0 after the second fetch. One full 4-beat drain after both results → accept_ok=1.
- FIFO full and out_ready=0, then cipher_valid → overflow=1 and stays 1. The stored contents are unchanged.
- FIFO full, cipher_valid coincident with a final-beat pop → no overflow. The new entry is streamed after the remaining entry.
- out_ready pattern 1,0,0,1,1,0,1 → exactly 4 beats transferred, each held stable while stalled.
- With MSKAES_OUTBUF_CLEAR_EN: after the last beat, sh_out_word=0 and the internal freed slot=0. Without the macro, the slot retains its data.
